// File: rtl/image_shear_engine_if.sv
// Bus bundle between the shear engine and BRAM port B:
// start/ready handshake, latched shear factor and the BRAM
// address/en/we/in_data/out_data signals.
interface image_shear_engine_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 11
);
  logic                  start;
  logic                  ready;
  logic signed [15:0]    shear;
  logic [ADDR_WIDTH-1:0] address;
  logic [WIDTH-1:0]      in_data;
  logic [WIDTH-1:0]      out_data;
  logic                  en;
  logic                  we;

  // Engine side: drives the BRAM port and reports readiness.
  modport master (
    input  start, shear, in_data,
    output ready, address, out_data, en, we
  );

  // Host/BRAM side: issues start and shear, returns read data.
  modport slave (
    output start, shear, in_data,
    input  ready, address, out_data, en, we
  );
endinterface

// File: rtl/image_shear_engine.sv
// Horizontal shear (deskew) engine. Reads an IMG_H x IMG_W image at
// SRC_BASE, shifts each row by a rounded fixed-point offset proportional
// to its distance from the vertical centre, and writes the result at
// DST_BASE. Nearest-neighbour sampling; out-of-image pixels become 0.
// One pixel every 3 cycles (RD, WAIT, WR) plus one OFFS cycle per row.
module image_shear_engine #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 11,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int SRC_BASE   = 0,
  parameter int DST_BASE   = 784,
  parameter int FRAC       = 8
) (
  input  logic          clk,
  input  logic          reset,
  image_shear_engine_if.master bus
);

  // Product of 16-bit shear and signed row distance, full width.
  localparam int PW = 16 + ADDR_WIDTH + 1;

  localparam logic [ADDR_WIDTH-1:0]   LAST_C   = ADDR_WIDTH'(IMG_W - 1);
  localparam logic [ADDR_WIDTH-1:0]   LAST_R   = ADDR_WIDTH'(IMG_H - 1);
  localparam logic [ADDR_WIDTH-1:0]   ROW_STEP = ADDR_WIDTH'(IMG_W);
  localparam logic [ADDR_WIDTH-1:0]   SRC_A    = ADDR_WIDTH'(SRC_BASE);
  localparam logic [ADDR_WIDTH-1:0]   DST_A    = ADDR_WIDTH'(DST_BASE);
  localparam logic signed [ADDR_WIDTH:0] CY_S  = (ADDR_WIDTH + 1)'(IMG_H / 2);
  localparam logic signed [PW:0]      COL_MAX  = (PW + 1)'(IMG_W - 1);
  localparam logic signed [PW-1:0]    HALF     = PW'(2 ** (FRAC - 1));

  typedef enum logic [2:0] {
    S_IDLE,
    S_OFFS,
    S_RD,
    S_WAIT,
    S_WR
  } state_t;

  // Add one half LSB and shift arithmetically: rounds half toward +inf.
  function automatic logic signed [PW-1:0] round_shift(
    input logic signed [PW-1:0] p
  );
    logic signed [PW-1:0] biased;
    biased = p + HALF;
    return biased >>> FRAC;
  endfunction

  // Source column must land inside the image row.
  function automatic logic col_in_range(input logic signed [PW:0] col);
    return !col[PW] && (col <= COL_MAX);
  endfunction

  state_t                state_q, state_d;
  logic signed [15:0]    shear_q;
  logic [ADDR_WIDTH-1:0] r_q, c_q;
  logic [ADDR_WIDTH-1:0] src_row_q, dst_row_q;

  logic signed [PW-1:0]  off_p0;
  logic                  in_rng_p1;
  logic [WIDTH-1:0]      pix_p2;

  logic signed [ADDR_WIDTH:0] row_rel;
  logic signed [PW-1:0]  shear_ext, row_ext, prod;
  logic signed [PW:0]    sc;
  logic                  sc_ok;

  assign row_rel   = $signed({1'b0, r_q}) - CY_S;
  assign shear_ext = {{(PW - 16){shear_q[15]}}, shear_q};
  assign row_ext   = {{(PW - ADDR_WIDTH - 1){row_rel[ADDR_WIDTH]}}, row_rel};
  assign prod      = shear_ext * row_ext;
  assign sc        = {{(PW + 1 - ADDR_WIDTH){1'b0}}, c_q} + {off_p0[PW-1], off_p0};
  assign sc_ok     = col_in_range(sc);

  // State register; reset returns to IDLE immediately, aborting any run.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Control: latched shear, pixel/row counters and row base accumulators.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shear_q   <= '0;
      r_q       <= '0;
      c_q       <= '0;
      src_row_q <= SRC_A;
      dst_row_q <= DST_A;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            shear_q   <= bus.shear;
            r_q       <= '0;
            c_q       <= '0;
            src_row_q <= SRC_A;
            dst_row_q <= DST_A;
          end
        end
        S_WR: begin
          if (c_q != LAST_C) begin
            c_q <= c_q + 1'b1;
          end else begin
            c_q <= '0;
            if (r_q != LAST_R) begin
              r_q       <= r_q + 1'b1;
              src_row_q <= src_row_q + ROW_STEP;
              dst_row_q <= dst_row_q + ROW_STEP;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath stages: row offset (p0), range flag (p1), captured pixel (p2).
  always_ff @(posedge clk) begin
    // p0: row offset, valid from RD of the current row
    if (state_q == S_OFFS) off_p0 <= round_shift(prod);
    // p1: whether this pixel's source column exists
    if (state_q == S_RD) in_rng_p1 <= sc_ok;
    // p2: read data arrives during WAIT; out-of-range pixels become 0
    if (state_q == S_WAIT) pix_p2 <= in_rng_p1 ? bus.in_data : '0;
  end

  // Next-state and BRAM port outputs, decoded from the current state.
  always_comb begin
    state_d      = state_q;
    bus.ready    = 1'b0;
    bus.en       = 1'b0;
    bus.we       = 1'b0;
    bus.address  = '0;
    bus.out_data = '0;
    case (state_q)
      S_IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) state_d = S_OFFS;
      end
      S_OFFS: begin
        state_d = S_RD;
      end
      S_RD: begin
        if (sc_ok) begin
          bus.en      = 1'b1;
          bus.address = src_row_q + sc[ADDR_WIDTH-1:0];
        end
        state_d = S_WAIT;
      end
      S_WAIT: begin
        state_d = S_WR;
      end
      S_WR: begin
        bus.en       = 1'b1;
        bus.we       = 1'b1;
        bus.address  = dst_row_q + c_q;
        bus.out_data = pix_p2;
        if (c_q != LAST_C)      state_d = S_RD;
        else if (r_q != LAST_R) state_d = S_OFFS;
        else                    state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/image_shear_engine.md
# image_shear_engine

Parametrised horizontal-shear (deskew) engine that reads an IMG_H x IMG_W image from a dual-port BRAM region, applies a run-time programmable fixed-point shear about the image's vertical centre using nearest-neighbour sampling, and writes the result to a second BRAM region. It connects to BRAM port B with the same start/ready and address/en/we/in_data/out_data interface as the current deskew stage. Port A stays free for the host to load images and read back results. Generalises the fixed 28x28 deskew to arbitrary image size, base addresses and shear factor.

## Interface
- WIDTH, 16, pixel/data width
- ADDR_WIDTH, 11, BRAM address width
- IMG_W, 28, image columns
- IMG_H, 28, image rows
- SRC_BASE, 0, word address of source pixel (0,0)
- DST_BASE, 784, word address of destination pixel (0,0)
- FRAC, 8, fractional bits of shear
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  start request, sampled only while ready=1
- ready  out  1  high when idle and able to accept start
- shear  in  16  signed Q(16-FRAC).FRAC shear factor, latched on accepted start
- address  out  ADDR_WIDTH  BRAM address
- in_data  in  WIDTH  BRAM read data, valid 1 cycle after a read (en=1, we=0)
- out_data  out  WIDTH  BRAM write data
- en  out  1  BRAM enable
- we  out  1  BRAM write enable

## Operation
- Pixel (r,c) is at SRC_BASE + r*IMG_W + c in the source and DST_BASE + r*IMG_W + c in the destination. Layout is row-major.
- CY = IMG_H/2 (integer division). Row offset: off(r) = (shear * (r - CY) + 2^(FRAC-1)) >>> FRAC.
  - The product is signed and full width (16 + ADDR_WIDTH + 1 bits).
  - This rounds half toward +infinity.
- Source column: sc = c + off(r). dst(r,c) = src(r,sc) if 0 <= sc <= IMG_W-1, else 0.
- Row base addresses are kept in accumulators (+IMG_W per row). The only multiplier is the one in OFFS.
- FSM states:
  - IDLE: ready=1, en=0, we=0. If start=1, latch shear, clear r and c, go to OFFS.
  - OFFS (1 cycle/row): compute and register off(r). Go to RD.
  - RD: if sc is in range, en=1, we=0, address = src row base + sc. Otherwise en=0. Go to WAIT.
  - WAIT: en=0. in_data becomes valid during this cycle. Go to WR.
  - WR: en=1, we=1, address = dst row base + c, out_data = in_data (in range) or 0. Then:
    - c < IMG_W-1: c++, go to RD.
    - c = IMG_W-1 and r < IMG_H-1: c=0, r++, go to OFFS.
    - last pixel: go to IDLE.
- Every destination word is written exactly once per run. No source word is ever written.
- A start seen outside IDLE is ignored. If start is held high across the end of a run, a new run starts (level-sampled in IDLE).

## Timing
- Reset (reset=0 at a rising edge): next cycle state=IDLE, ready=1, en=0, we=0, address=0, out_data=0. The latched shear is cleared to 0.
- Reset mid-run aborts at once. The destination is left partially written and the next start performs a full run.
- Accepted start at edge T: ready=0 from T+1. OFFS for row 0 runs in cycle T+1.
- Each pixel takes exactly 3 cycles (RD, WAIT, WR) whether in range or not. Each row adds 1 OFFS cycle.
- Run latency is fixed: IMG_H*(1 + 3*IMG_W) cycles from the start-accept edge to ready=1. This is 2380 cycles for 28x28.
- Write ordering: dst(r,c) WR precedes dst(r,c+1) RD. Because source and destination regions do not overlap, there is no read-after-write hazard.
- out_data is don't-care when we=0. address is don't-care when en=0. The bench checks these only when they are qualified.

## Test plan
- shear=0x0000, src[i]=i for i=0..783 -> dst[784+i]=i for all i. ready returns exactly 2380 cycles after the start-accept edge.
- shear=0x0100 (1.0), src[i]=i -> off(0)=-14 and off(27)=13.
  - dst(0,c)=src(0,c-14) for c>=14, 0 for c<14.
  - Row 14 is an identity copy.
  - dst(27,c)=src(27,c+13) for c<=14, 0 for c>14.
- shear=0xFF80 (-0.5) -> off(0)=7, off(1)=7 (6.5 rounds up), off(15)=0 (-0.5 rounds to 0), off(16)=-1. Check every row against the rule.
- start held high for 3 cycles, then pulsed again at cycle 500 with shear changed -> exactly one run, using the shear latched at the first accept. Total write count is 784 and ready=0 throughout.
- reset driven low for 1 cycle after 100 writes -> next cycle en=0, we=0, ready=1. A following start with shear=0 rewrites all 784 destination words correctly.
- Variant IMG_W=8, IMG_H=4, SRC_BASE=0, DST_BASE=32, shear=0x0100 -> off(r) = -2, -1, 0, 1 for rows 0..3. Latency is 100 cycles and there are no writes outside 32..63.
